// File: rtl/up_sample_pkg.sv
// Shared types and constants for the up_sample_and_expand block.
package up_sample_pkg;

    // Output sequencer states: waiting for a sample, or emitting its outputs.
    typedef enum logic {
        StIdle,
        StEmit
    } state_e;

    // Mid-scale code of the unsigned input; maps to signed zero.
    localparam logic [7:0] SAMPLE_OFFSET = 8'h80;

endpackage

// File: rtl/interp_ramp.sv
// interp_ramp: linear ramp from the previous sample to the current one.
// Output k of a block is prev + floor((cur - prev) * k / 2**RAMP_SHIFT).
module interp_ramp #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned RAMP_SHIFT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_advance,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    output logic [SAMPLE_WIDTH-1:0] o_data
);

    // One guard bit for the difference plus RAMP_SHIFT bits of scaling.
    localparam int unsigned ACC_W = SAMPLE_WIDTH + 1 + RAMP_SHIFT;
    localparam int unsigned EXT_W = ACC_W - SAMPLE_WIDTH;

    logic [SAMPLE_WIDTH-1:0] r_prev;
    logic [SAMPLE_WIDTH-1:0] r_cur;
    logic signed [ACC_W-1:0] r_ramp;
    logic signed [ACC_W-1:0] w_prev_ext;
    logic signed [ACC_W-1:0] w_cur_ext;
    logic signed [ACC_W-1:0] w_step;
    logic signed [ACC_W-1:0] w_acc;
    logic                    w_unused_bits;

    assign w_prev_ext = {{EXT_W{r_prev[SAMPLE_WIDTH-1]}}, r_prev};
    assign w_cur_ext  = {{EXT_W{r_cur[SAMPLE_WIDTH-1]}}, r_cur};
    assign w_step     = w_cur_ext - w_prev_ext;

    // acc = prev * F + (cur - prev) * k; the arithmetic shift below floors it.
    assign w_acc  = (w_prev_ext <<< RAMP_SHIFT) + r_ramp;
    assign o_data = w_acc[RAMP_SHIFT +: SAMPLE_WIDTH];

    // Guard bit and fraction bits are never part of the output value.
    assign w_unused_bits = ^{w_acc[ACC_W-1], w_acc[RAMP_SHIFT-1:0]};

    // Sample history: prev takes the old cur before the new cur is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_cur  <= '0;
        end else if (i_load) begin
            r_prev <= r_cur;
            r_cur  <= i_sample;
        end
    end

    // Ramp accumulator: cleared on a new sample, stepped on each taken output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp <= '0;
        end else if (i_load) begin
            r_ramp <= '0;
        end else if (i_advance) begin
            r_ramp <= r_ramp + w_step;
        end
    end

endmodule

// File: rtl/up_sample_and_expand.sv
// up_sample_and_expand: takes unsigned samples and emits INTERP_FACTOR signed
// samples per input. Build option LINEAR_INTERP_EN selects linear interpolation
// (via interp_ramp); without it the block is a zero-order hold.
module up_sample_and_expand
    import up_sample_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH  = 8,
    parameter int unsigned DATA_OUT_WIDTH = 16,
    parameter int unsigned INTERP_FACTOR  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      underrun
);

    localparam int unsigned CNT_W = $clog2(INTERP_FACTOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERP_FACTOR - 1);
    localparam int unsigned PAD_W = DATA_OUT_WIDTH - DATA_IN_WIDTH;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic                      r_underrun;
    logic                      w_underrun_next;
    logic                      w_take;
    logic                      w_last;
    logic                      w_accept;
    logic [DATA_IN_WIDTH-1:0]  w_centered;
    logic [DATA_OUT_WIDTH-1:0] w_sample;

    // Removing the offset and left-aligning gives (data_in - 128) << 8.
    assign w_centered = data_in - DATA_IN_WIDTH'(SAMPLE_OFFSET);
    assign w_sample   = {w_centered, {PAD_W{1'b0}}};

    assign valid_out = (r_state == StEmit);
    assign w_take    = valid_out & ready_out;
    assign w_last    = (r_cnt == CNT_LAST);
    // A new sample may land in the same cycle the last output leaves.
    assign ready_in  = (r_state == StIdle) | (w_take & w_last);
    assign w_accept  = valid_in & ready_in;
    assign underrun  = r_underrun;

    // Next-state, output index and starvation pulse.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_underrun_next = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StEmit;
                    w_cnt_next   = '0;
                end
            end
            StEmit: begin
                if (w_take) begin
                    if (w_last) begin
                        w_cnt_next = '0;
                        if (!w_accept) begin
                            w_state_next    = StIdle;
                            w_underrun_next = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_underrun <= w_underrun_next;
        end
    end

`ifdef LINEAR_INTERP_EN
    logic w_advance;

    // The wrap step is never stepped: the next block reloads the ramp.
    assign w_advance = w_take & ~w_last;

    interp_ramp #(
        .SAMPLE_WIDTH (DATA_OUT_WIDTH),
        .RAMP_SHIFT   (CNT_W)
    ) u_interp_ramp (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_advance (w_advance),
        .i_sample  (w_sample),
        .o_data    (data_out)
    );
`else
    logic [DATA_OUT_WIDTH-1:0] r_cur;

    // Zero-order hold: the converted sample is repeated in every output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
        end else if (w_accept) begin
            r_cur <= w_sample;
        end
    end

    assign data_out = r_cur;
`endif

endmodule

// File: tb/tb_up_sample_and_expand.sv
// Bench for up_sample_and_expand with INTERP_FACTOR = 4. A queue-based model
// predicts every output; literal tables pin the model for both build options.
module tb_up_sample_and_expand;

    localparam int F = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [7:0]  data_in = 8'h00;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [15:0] data_out;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_underrun = 0;
    int n_takes = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int          m_prev = 0;
    int          m_cur = 0;
    logic        exp_underrun = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] stall_data = 16'h0;

    logic [7:0]  pin_in[5] = '{8'hC0, 8'h40, 8'hFF, 8'h00, 8'h80};
`ifdef LINEAR_INTERP_EN
    logic [15:0] pin_out[20] = '{
        16'h0000, 16'h1000, 16'h2000, 16'h3000,
        16'h4000, 16'h2000, 16'h0000, 16'hE000,
        16'hC000, 16'hEFC0, 16'h1F80, 16'h4F40,
        16'h7F00, 16'h3F40, 16'hFF80, 16'hBFC0,
        16'h8000, 16'hA000, 16'hC000, 16'hE000};
    logic [15:0] post_rst_out[4] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000};
`else
    logic [15:0] pin_out[20] = '{
        16'h4000, 16'h4000, 16'h4000, 16'h4000,
        16'hC000, 16'hC000, 16'hC000, 16'hC000,
        16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
        16'h8000, 16'h8000, 16'h8000, 16'h8000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] post_rst_out[4] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
`endif

    up_sample_and_expand #(
        .DATA_IN_WIDTH  (8),
        .DATA_OUT_WIDTH (16),
        .INTERP_FACTOR  (F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Model and compare: runs on every falling edge, away from the active edge.
    always @(negedge clk) begin
        logic take;
        logic acc;
        int   e;
        if (rst) begin
            check("rst_valid_out", {31'b0, valid_out}, 32'd0);
            check("rst_data_out", {16'b0, data_out}, 32'd0);
            check("rst_underrun", {31'b0, underrun}, 32'd0);
            exp_q.delete();
            m_prev = 0;
            m_cur = 0;
            exp_underrun = 1'b0;
            stall = 1'b0;
        end else begin
            check("valid_out", {31'b0, valid_out}, {31'b0, exp_q.size() != 0});
            check("ready_in", {31'b0, ready_in},
                  {31'b0, (exp_q.size() == 0) || (exp_q.size() == 1 && ready_out)});
            check("underrun", {31'b0, underrun}, {31'b0, exp_underrun});
            if (underrun) n_underrun++;
            if (stall && valid_out) check("stall_hold", {16'b0, data_out}, {16'b0, stall_data});
            take = valid_out && ready_out;
            acc = valid_in && ready_in;
            exp_underrun = 1'b0;
            if (take) begin
                n_takes++;
                got.push_back(data_out);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_output: got 0x%0h want none", data_out);
                end else begin
                    check("data_out", {16'b0, data_out}, {16'b0, exp_q.pop_front()});
                    if (exp_q.size() == 0 && !acc) exp_underrun = 1'b1;
                end
            end
            if (acc) begin
                m_prev = m_cur;
                m_cur = (int'(data_in) - 128) * 256;
                for (int k = 0; k < F; k++) begin
`ifdef LINEAR_INTERP_EN
                    e = m_prev + floor_div((m_cur - m_prev) * k, F);
`else
                    e = m_cur;
`endif
                    exp_q.push_back(e[15:0]);
                end
            end
            stall = valid_out && !ready_out;
            stall_data = data_out;
        end
    end

    task automatic send(input logic [7:0] d);
        bit done = 1'b0;
        data_in = d;
        valid_in = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready_in) done = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no accept want accept of 0x%0h", d);
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!valid_out) idle = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!idle) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got valid_out=1 want 0");
        end
    endtask

    initial begin
        int u0;
        int t0;
        #1 rst = 1'b1;
        #2;
        check("reset_valid_out", {31'b0, valid_out}, 32'd0);
        check("reset_data_out", {16'b0, data_out}, 32'h0000);
        check("reset_underrun", {31'b0, underrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_in_after_rst", {31'b0, ready_in}, 32'd1);

        // Literal pins: five back-to-back samples from the reset state.
        got.delete();
        foreach (pin_in[i]) send(pin_in[i]);
        wait_idle();
        check("pin_count", got.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < got.size()) check($sformatf("pin_out[%0d]", i), {16'b0, got[i]},
                                      {16'b0, pin_out[i]});
        end

        // Backpressure: stall for 5 cycles with cnt = 1 and a sample waiting.
        t0 = n_takes;
        valid_in = 1'b1;
        data_in = 8'hA0;
        @(posedge clk);
        #1;
        data_in = 8'h20;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready_in", {31'b0, ready_in}, 32'd0);
            check("bp_valid_out", {31'b0, valid_out}, 32'd1);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        send(8'h20);
        wait_idle();
        check("bp_take_count", n_takes - t0, 32'd8);

        // Streaming: each new sample lands with the last output of the previous.
        u0 = n_underrun;
        send(8'h10);
        send(8'h90);
        send(8'hF0);
        send(8'h30);
        check("stream_no_underrun", n_underrun - u0, 32'd0);
        wait_idle();
        check("starve_one_underrun", n_underrun - u0, 32'd1);
        check("starve_valid_out", {31'b0, valid_out}, 32'd0);
        check("starve_ready_in", {31'b0, ready_in}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("starve_single_pulse", n_underrun - u0, 32'd1);

        // Reset in the middle of a block, at cnt = 2.
        send(8'hFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid_out", {31'b0, valid_out}, 32'd0);
        check("midrst_data_out", {16'b0, data_out}, 32'h0000);
        check("midrst_underrun", {31'b0, underrun}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
        send(8'hC0);
        wait_idle();
        check("post_rst_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check($sformatf("post_rst_out[%0d]", i), {16'b0, got[i]},
                                      {16'b0, post_rst_out[i]});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
